// File: rtl/led_pwm_pkg.sv
`default_nettype none
//==============================================================================
// Module  : led_pwm_pkg
// Brief   : Shared mode encodings and the triangle-fold helper for the
//           multi-channel LED breathing PWM driver.
// Rev     : 1.0  initial release
//==============================================================================
package led_pwm_pkg;

    // Operating modes, stepped in this order by each accepted key press
    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_STATIC = 2'd1;
    localparam logic [1:0] MODE_BREATH = 2'd2;
    localparam logic [1:0] MODE_WAVE   = 2'd3;

    // Map a phase q in 0..2*span-1 onto a triangle that rises from 1 to
    // 1+span and falls back again, so the duty never leaves [1, 1+span].
    function automatic logic [31:0] fold(input logic [31:0] q, input logic [31:0] span);
        logic [31:0] w_val;
        if (q <= span) begin
            w_val = 32'd1 + q;
        end else begin
            w_val = 32'd1 + (span << 1) - q;
        end
        return w_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
//==============================================================================
// Module  : key_debounce
// Brief   : Synchronises the raw active-low mode key, accepts a new level only
//           after it has been stable for DEB_CYCLES clocks, and emits a single
//           press pulse on each accepted released->pressed transition.
// Rev     : 1.0  initial release
//==============================================================================
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_d,
    output logic press,
    output logic key_level
);

    // Run length saturates at DEB_CYCLES, so the counter needs to hold that value
    localparam int                 c_CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEB_CYCLES);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_q;
    logic               r_level;
    logic               r_armed;
    logic [c_CNT_W-1:0] r_run;
    logic [c_CNT_W-1:0] w_run;
    logic               w_stable;
    logic               w_accept;

    // Two-flop synchroniser; idles at the released level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_d;
            r_sync2 <= r_sync1;
        end
    end

    // Length of the current run of identical synchronised samples, this cycle included
    always_comb begin
        if (r_sync2 != r_sync_q) begin
            w_run = c_CNT_W'(1);
        end else if (r_run == c_FULL) begin
            w_run = c_FULL;
        end else begin
            w_run = r_run + c_CNT_W'(1);
        end
        w_stable = (w_run == c_FULL);
        w_accept = w_stable && (r_sync2 != r_level);
    end

    // Run tracking, accepted level and arming. A key held through reset is
    // first accepted as pressed without stepping; only after a confirmed
    // release does the next press count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_q <= 1'b1;
            r_run    <= '0;
            r_level  <= 1'b1;
            r_armed  <= 1'b0;
        end else begin
            r_sync_q <= r_sync2;
            r_run    <= w_run;
            if (w_accept) begin
                r_level <= r_sync2;
            end
            if (w_stable && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign press     = w_accept && !r_sync2 && r_armed;
    assign key_level = r_level;

endmodule
`default_nettype wire

// File: rtl/led_breath_pwm.sv
`default_nettype none
//==============================================================================
// Module  : led_breath_pwm
// Brief   : Multi-channel LED PWM driver. A prescaled phase accumulator drives
//           an overshoot-free triangle ramp; a debounced key cycles through
//           OFF / STATIC / BREATH / WAVE modes. WAVE offsets each channel's
//           phase by PHASE_STEP ticks. Outputs are registered.
// Rev     : 1.0  initial release
//==============================================================================
module led_breath_pwm
    import led_pwm_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int PWM_W       = 10,
    parameter int TICK_DIV    = 20000,
    parameter int DEB_CYCLES  = 50000,
    parameter int PHASE_STEP  = 64,
    parameter int STATIC_DUTY = 512,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            key_d,
    output logic [N_CH-1:0] LED,
    output logic [1:0]      mode_o
);

    // Ramp spans duty 1 .. 2^PWM_W-2, so SPAN = 2^PWM_W-3 and one full
    // up/down period is 2*SPAN ticks; the phase needs one extra bit.
    localparam int                 c_SPAN    = (2 ** PWM_W) - 3;
    localparam int                 c_PER     = 2 * c_SPAN;
    localparam int                 c_PH_W    = PWM_W + 1;
    localparam int                 c_PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PS_W-1:0]  c_PS_LAST = c_PS_W'(TICK_DIV - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST = c_PH_W'(c_PER - 1);
    localparam logic [c_PH_W:0]    c_PER_V   = (c_PH_W + 1)'(c_PER);
    localparam logic [PWM_W-1:0]   c_STATIC  = PWM_W'(STATIC_DUTY);
    localparam logic               c_POL     = (ACTIVE_LOW != 0);

    logic              r_rst_meta_n;
    logic              r_rst_sync_n;
    logic [c_PS_W-1:0] r_presc;
    logic [c_PH_W-1:0] r_phase;
    logic [PWM_W-1:0]  r_pwm_cnt;
    logic [1:0]        r_mode;
    logic [N_CH-1:0]   r_led;
    logic              w_tick;
    logic              w_press;
    logic              w_key_level;
    logic              w_step;
    logic [PWM_W-1:0]  w_fold_p;
    logic [N_CH-1:0]   w_on;

    // Reset asserts asynchronously and is released two clocks later in sync with clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_meta_n <= 1'b0;
            r_rst_sync_n <= 1'b0;
        end else begin
            r_rst_meta_n <= 1'b1;
            r_rst_sync_n <= r_rst_meta_n;
        end
    end

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clk       (clk),
        .reset_n   (r_rst_sync_n),
        .key_d     (key_d),
        .press     (w_press),
        .key_level (w_key_level)
    );

    // A step is taken only on the edge out of the released level
    assign w_step = w_press && w_key_level;
    assign w_tick = (r_presc == c_PS_LAST);

    // Prescaler, ramp phase and PWM counter; the phase advances once per tick
    always_ff @(posedge clk or negedge r_rst_sync_n) begin
        if (!r_rst_sync_n) begin
            r_presc   <= '0;
            r_phase   <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_presc   <= w_tick ? '0 : r_presc + c_PS_W'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (w_tick) begin
                r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + c_PH_W'(1);
            end
        end
    end

    // Mode register; steps once per accepted press, independent of the ramp
    always_ff @(posedge clk or negedge r_rst_sync_n) begin
        if (!r_rst_sync_n) begin
            r_mode <= MODE_BREATH;
        end else if (w_step) begin
            r_mode <= r_mode + 2'd1;
        end
    end

    // Common breathing duty shared by all channels
    always_comb begin
        w_fold_p = PWM_W'(fold(32'(r_phase), 32'(c_SPAN)));
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam int              c_OFF   = (gi * PHASE_STEP) % c_PER;
        localparam logic [c_PH_W:0] c_OFF_V = (c_PH_W + 1)'(c_OFF);

        logic [c_PH_W:0]   w_sum;
        logic [c_PH_W-1:0] w_q;
        logic [PWM_W-1:0]  w_duty;

        // Channel duty by mode; WAVE folds the phase shifted by this channel's offset
        always_comb begin
            w_sum = {1'b0, r_phase} + c_OFF_V;
            if (w_sum >= c_PER_V) begin
                w_q = c_PH_W'(w_sum - c_PER_V);
            end else begin
                w_q = w_sum[c_PH_W-1:0];
            end
            case (r_mode)
                MODE_OFF:    w_duty = '0;
                MODE_STATIC: w_duty = c_STATIC;
                MODE_BREATH: w_duty = w_fold_p;
                default:     w_duty = PWM_W'(fold(32'(w_q), 32'(c_SPAN)));
            endcase
        end

        assign w_on[gi] = (r_pwm_cnt < w_duty);
    end

    // Registered LED pins with board polarity applied
    always_ff @(posedge clk or negedge r_rst_sync_n) begin
        if (!r_rst_sync_n) begin
            r_led <= {N_CH{c_POL}};
        end else begin
            r_led <= w_on ^ {N_CH{c_POL}};
        end
    end

    assign LED    = r_led;
    assign mode_o = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_led_breath_pwm.sv
`default_nettype none
//==============================================================================
// Module  : tb_led_breath_pwm
// Brief   : Self-checking bench for led_breath_pwm. Two instances (active-low
//           with STATIC_DUTY=15, active-high with STATIC_DUTY=0) share the key
//           and reset stimulus; a behavioural model queues the expected pins
//           every clock and a monitor compares them on the falling edge.
// Rev     : 1.0  initial release
//==============================================================================
module tb_led_breath_pwm;

    localparam int N_CH       = 4;
    localparam int PWM_W      = 4;
    localparam int TICK_DIV   = 4;
    localparam int DEB_CYCLES = 8;
    localparam int PHASE_STEP = 3;
    localparam int SPAN       = 13;
    localparam int PER        = 2 * SPAN;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] m;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_d;
    logic [3:0] led_a;
    logic [3:0] led_b;
    logic [1:0] mode_a;
    logic [1:0] mode_b;

    int   ncmp = 0;
    int   nerr = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    // Reference model state
    int         m_presc, m_ph, m_pwm, m_mode, m_stage;
    bit         m_s1, m_s2, m_level, m_armed;
    bit         m_hist[$];
    logic [3:0] m_led_a, m_led_b;

    always #5 clk = ~clk;

    led_breath_pwm #(
        .N_CH(N_CH), .PWM_W(PWM_W), .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES),
        .PHASE_STEP(PHASE_STEP), .STATIC_DUTY(15), .ACTIVE_LOW(1)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .key_d(key_d), .LED(led_a), .mode_o(mode_a)
    );

    led_breath_pwm #(
        .N_CH(N_CH), .PWM_W(PWM_W), .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES),
        .PHASE_STEP(PHASE_STEP), .STATIC_DUTY(0), .ACTIVE_LOW(0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .key_d(key_d), .LED(led_b), .mode_o(mode_b)
    );

    function automatic int fold_ref(input int q);
        return (q <= SPAN) ? (1 + q) : (1 + 2 * SPAN - q);
    endfunction

    function automatic int duty_ref(input int mode, input int ch, input int p, input int sd);
        case (mode)
            0:       return 0;
            1:       return sd;
            2:       return fold_ref(p);
            default: return fold_ref((p + ch * PHASE_STEP) % PER);
        endcase
    endfunction

    function automatic logic [3:0] led_ref(input int mode, input int p, input int cnt,
                                           input int sd, input bit al);
        logic [3:0] v;
        for (int ch = 0; ch < N_CH; ch++) begin
            v[ch] = (cnt < duty_ref(mode, ch, p, sd)) ^ al;
        end
        return v;
    endfunction

    function automatic bit hist_stable();
        if (m_hist.size() != DEB_CYCLES) return 1'b0;
        foreach (m_hist[k]) begin
            if (m_hist[k] != m_hist[0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_presc = 0; m_ph = 0; m_pwm = 0; m_mode = 2;
        m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b1; m_armed = 1'b0;
        m_hist.delete();
        m_led_a = 4'b1111; m_led_b = 4'b0000;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Behavioural model: one step per clock edge, expected pins queued per cycle
    initial begin : p_model
        bit rn, kd, active, stable, press, tick;
        model_reset();
        m_stage = 0;
        forever begin
            @(posedge clk);
            rn = reset_n;
            kd = key_d;
            active = (m_stage == 2) && rn;
            if (active) begin
                m_led_a = led_ref(m_mode, m_ph, m_pwm, 15, 1'b1);
                m_led_b = led_ref(m_mode, m_ph, m_pwm, 0, 1'b0);
                m_hist.push_back(m_s2);
                if (m_hist.size() > DEB_CYCLES) void'(m_hist.pop_front());
                stable = hist_stable();
                press  = stable && !m_s2 && m_level && m_armed;
                if (stable) m_level = m_s2;
                if (stable && m_s2) m_armed = 1'b1;
                m_s2 = m_s1;
                m_s1 = kd;
                tick = (m_presc == TICK_DIV - 1);
                m_presc = tick ? 0 : m_presc + 1;
                if (tick) m_ph = (m_ph + 1) % PER;
                m_pwm = (m_pwm + 1) % (2 ** PWM_W);
                if (press) m_mode = (m_mode + 1) % 4;
            end
            m_stage = rn ? ((m_stage < 2) ? m_stage + 1 : 2) : 0;
            #2;
            if (!reset_n) begin
                model_reset();
                m_stage = 0;
            end
            sb_q.push_back({m_led_a, m_led_b, 2'(m_mode)});
        end
    end

    // Monitor: compares the pins against the queued expectation each falling edge
    initial begin : p_monitor
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("led_a",  led_a, mon_e.a);
                check("led_b",  led_b, mon_e.b);
                check("mode_a", {2'b00, mode_a}, {2'b00, mon_e.m});
                check("mode_b", {2'b00, mode_b}, {2'b00, mon_e.m});
            end
        end
    end

    // Drive key/reset, then hold for n clocks; changes land 1 time unit after an edge
    task automatic hold(input bit k, input bit r, input int n);
        if (n == 0) return;
        key_d   = k;
        reset_n = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_key(input int lo, input int hi);
        hold(1'b0, 1'b1, lo);
        hold(1'b1, 1'b1, hi);
    endtask

    initial begin : p_stim
        hold(1'b1, 1'b0, 4);
        hold(1'b1, 1'b1, 130);                   // BREATH ramp, more than one period
        push_key(20, 120);                       // -> WAVE
        push_key(5, 20);                         // short glitch, no step
        hold(1'b0, 1'b1, 20);                    // press held, then bouncy release -> OFF
        repeat (4) begin
            hold(1'b1, 1'b1, 2);
            hold(1'b0, 1'b1, 2);
        end
        hold(1'b1, 1'b1, 40);
        push_key(20, 40);                        // -> STATIC
        push_key(20, 40);                        // -> BREATH
        for (int k = 0; k < 8; k++) begin        // sweep press alignment against ticks
            hold(1'b1, 1'b1, k);
            push_key(12, 15);
        end
        hold(1'b0, 1'b1, 5);                     // reset during debounce, key held
        hold(1'b0, 1'b0, 3);
        hold(1'b0, 1'b1, 30);
        hold(1'b1, 1'b1, 20);
        push_key(15, 20);
        hold(1'b1, 1'b1, 57);                    // reset mid-ramp
        hold(1'b1, 1'b0, 2);
        hold(1'b1, 1'b1, 30);
        for (int k = 0; k < 40; k++) begin
            hold(1'b0, 1'b1, int'($urandom_range(1, 20)));
            hold(1'b1, 1'b1, int'($urandom_range(1, 20)));
            if ($urandom_range(0, 15) == 0) begin
                hold(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 3)));
            end
        end
        hold(1'b1, 1'b1, 40);
        @(negedge clk);
        #1;
        ncmp++;
        if (sb_q.size() > 1) begin
            nerr++;
            $display("FAIL scoreboard_drain: got %0d pending expected at most 1", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire
